node_info_mgr: RTL and testbench
================================

Name: node_info_mgr

Overview:
Parametrised successor of the node-info register block for the EER-RL cluster node. It tracks the node's hop distance to sink, cluster-head role, assigned CH and TDMA timeslot, and a low-energy flag with hysteresis. It also computes the normalised-energy Q value (energy - e_min)/(e_max - e_min) with a multi-cycle restoring divider and a busy/valid handshake. It sits between the packet decoder (fPktType plus fields) and the RL next-hop selector.

Parameters:
WIDTH, 16, width of all energy/Q/ID/hop/timeslot words
FRAC, 14, fractional bits of the fixed-point energy and Q format (1.0 = 1<<FRAC)
MY_NODE_ID, 16'h0001, this node's ID, driven on myNodeID
MAX_HOPS, 16'hFFFF, "unknown" hop value; also the saturation limit
HYST, 16'h0333, low_E release hysteresis (about 0.05 in 2.14)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
en_MNI  in  1  packet-field strobe; accepted only when busy=0
fPktType  in  3  0=HB, 1=CHE (CH announce), 2=CHT (timeslot assign), 3=DATA, others=none
e_max  in  WIDTH  network max energy (HB)
e_min  in  WIDTH  network min energy (HB)
energy  in  WIDTH  own residual energy
ch_ID  in  WIDTH  CH ID field (CHE/CHT)
hops  in  WIDTH  sender's hop count (HB)
timeslot  in  WIDTH  TDMA slot (CHT)
e_threshold  in  WIDTH  low-energy threshold
myNodeID  out  WIDTH  constant MY_NODE_ID
hopsFromSink  out  WIDTH  best known hop count
myQValue  out  WIDTH  normalised energy Q, FRAC fractional bits
role  out  1  1 = this node is CH
low_E  out  1  low-energy flag
myCH  out  WIDTH  assigned cluster head ID
myTimeslot  out  WIDTH  assigned TDMA slot
busy  out  1  divider running; en_MNI ignored
q_valid  out  1  one-cycle pulse when myQValue is updated

Behaviour:
- Reset (async, nrst=0): hopsFromSink=MAX_HOPS, myQValue=0, role=0, low_E=0, myCH=0, myTimeslot=0, busy=0, q_valid=0. FSM goes to IDLE. Any division in progress is aborted and its result discarded. myNodeID is constant.
- Accept: on a rising edge with en_MNI=1, busy=0 and a decoded fPktType. While busy=1, en_MNI is ignored entirely (no field updates). Upstream must hold or retry.
- HB accept:
  - If hops < MAX_HOPS-1 and hops+1 < hopsFromSink, set hopsFromSink = hops+1. Otherwise it is unchanged; hops >= MAX_HOPS-1 never updates.
  - Latch num = energy - e_min and den = e_max - e_min. Degenerate flag = (energy <= e_min) or (e_max <= e_min).
  - Go to DIV.
- CHE accept: role = (ch_ID == MY_NODE_ID); myCH = ch_ID.
- CHT accept: if ch_ID == myCH, myTimeslot = timeslot; otherwise ignored.
- DATA/other accept: no state change.
- low_E (any accepted packet, including HB): set when energy < e_threshold. Clear when energy >= e_threshold + HYST; the sum is saturating at all-ones. Otherwise hold.
- FSM IDLE -> DIV -> DONE -> IDLE. QBITS = FRAC+1.
  - DIV: restoring divide of (num << FRAC)/den, one quotient bit per cycle, for QBITS cycles. Internal width is WIDTH+FRAC+1.
  - DONE: write myQValue, pulse q_valid for one cycle, clear busy.
- Result rules:
  - Degenerate: myQValue = 0.
  - Quotient > 1<<FRAC: saturate to 1<<FRAC (e.g. energy > e_max).
  - Latency is uniform: busy rises the cycle after the accept edge; q_valid and the new myQValue appear QBITS+1 cycles after the accept edge (16 cycles for FRAC=14). Degenerate cases also take the full latency.
- myQValue holds its previous value during DIV.
- en_MNI asserted in the same cycle q_valid pulses: accepted (busy is already 0).

Decomposition:
- Package node_info_pkg holds:
  - pkt_type_e enum (PKT_HB=0, PKT_CHE=1, PKT_CHT=2, PKT_DATA=3, PKT_NONE=7)
  - FSM state enum (IDLE, DIV, DONE)
  - Q_ONE = 1<<FRAC helper
- One sub-module: q_norm_div. It is the sequential restoring divider with start/busy/done handshake and saturation, parametrised by WIDTH and FRAC.

Test Plan:
1. Reset, then HB with hops=1, e_max=0x8000, e_min=0x4000, energy=0x8000, e_threshold=0x3333 -> hopsFromSink=2, busy for 16 cycles, q_valid pulse, myQValue=0x4000, low_E=0.
2. HB with energy=0x6000 (same range) -> myQValue=0x2000. Second HB with hops=5 -> hopsFromSink stays 2. HB with hops=0 -> hopsFromSink=1.
3. Degenerate: HB with e_max=e_min=0x4000 -> myQValue=0. HB with energy=0x3000 -> myQValue=0. HB with energy=0xA000 -> myQValue=0x4000 (saturated).
4. CHE ch_ID=0x0001 -> role=1, myCH=1. CHT ch_ID=1, timeslot=7 -> myTimeslot=7. CHT ch_ID=9, timeslot=3 -> myTimeslot stays 7. CHE ch_ID=5 -> role=0.
5. low_E hysteresis (e_threshold=0x3333): energy=0x3000 -> low_E=1. energy=0x3400 -> still 1. energy=0x3700 -> 0.
6. en_MNI pulsed mid-DIV with CHE ch_ID=1 -> ignored, role unchanged. nrst pulsed mid-DIV -> all outputs at reset values, no q_valid. A new HB afterwards completes normally.

Source files
------------

// File: rtl/node_info_pkg.sv
// Shared types for the node-info manager: packet codes, divider FSM states,
// and the fixed-point unity helper.
package node_info_pkg;

    typedef enum logic [2:0] {
        PKT_HB   = 3'd0,
        PKT_CHE  = 3'd1,
        PKT_CHT  = 3'd2,
        PKT_DATA = 3'd3,
        PKT_NONE = 3'd7
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] q_one(input int frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/q_norm_div.sv
// Sequential restoring divider computing (num << FRAC) / den, one quotient
// bit per cycle, with degenerate-zero and unity saturation.
module q_norm_div
    import node_info_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             degen,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int QBITS = FRAC + 1;
    localparam int DW    = WIDTH + FRAC + 1;
    localparam int CW    = $clog2(QBITS + 1);
    localparam logic [WIDTH-1:0] QONE = WIDTH'(q_one(FRAC));

    div_state_e state, nxt;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    rem;
    logic [DW-1:0]    dsr;
    logic [QBITS-1:0] quo;
    logic             sat;
    logic             dgn;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = DIV;
            DIV:     if (cnt == CW'(QBITS - 1)) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Divisor starts aligned to the unity bit and walks right each cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rem <= '0;
            dsr <= '0;
            quo <= '0;
            cnt <= '0;
            sat <= 1'b0;
            dgn <= 1'b0;
        end else if (state == IDLE && start) begin
            rem <= DW'(num) << FRAC;
            dsr <= DW'(den) << FRAC;
            quo <= '0;
            cnt <= '0;
            sat <= num > den;
            dgn <= degen;
        end else if (state == DIV) begin
            if (rem >= dsr) begin
                rem <= rem - dsr;
                quo <= {quo[QBITS-2:0], 1'b1};
            end else begin
                quo <= {quo[QBITS-2:0], 1'b0};
            end
            dsr <= dsr >> 1;
            cnt <= cnt + CW'(1);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign q    = dgn ? '0 : (sat ? QONE : WIDTH'(quo));

endmodule

// File: rtl/node_info_mgr.sv
// Node-info register block: hop distance, CH role/assignment, timeslot,
// low-energy flag with hysteresis and normalised-energy Q value.
module node_info_mgr
    import node_info_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               FRAC       = 14,
    parameter logic [WIDTH-1:0] MY_NODE_ID = 'h0001,
    parameter logic [WIDTH-1:0] MAX_HOPS   = '1,
    parameter logic [WIDTH-1:0] HYST       = 'h0333
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en_MNI,
    input  logic [2:0]       fPktType,
    input  logic [WIDTH-1:0] e_max,
    input  logic [WIDTH-1:0] e_min,
    input  logic [WIDTH-1:0] energy,
    input  logic [WIDTH-1:0] ch_ID,
    input  logic [WIDTH-1:0] hops,
    input  logic [WIDTH-1:0] timeslot,
    input  logic [WIDTH-1:0] e_threshold,
    output logic [WIDTH-1:0] myNodeID,
    output logic [WIDTH-1:0] hopsFromSink,
    output logic [WIDTH-1:0] myQValue,
    output logic             role,
    output logic             low_E,
    output logic [WIDTH-1:0] myCH,
    output logic [WIDTH-1:0] myTimeslot,
    output logic             busy,
    output logic             q_valid
);

    logic             is_hb, is_che, is_cht, known, acc;
    logic             div_busy, div_done, degen;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   thr_sum;
    logic [WIDTH-1:0] thr_hi;

    assign is_hb  = (fPktType == PKT_HB);
    assign is_che = (fPktType == PKT_CHE);
    assign is_cht = (fPktType == PKT_CHT);
    assign known  = is_hb | is_che | is_cht | (fPktType == PKT_DATA);
    assign acc    = en_MNI & ~div_busy & known;

    assign thr_sum = {1'b0, e_threshold} + {1'b0, HYST};
    assign thr_hi  = thr_sum[WIDTH] ? '1 : thr_sum[WIDTH-1:0];
    assign degen   = (energy <= e_min) | (e_max <= e_min);

    q_norm_div #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_div (
        .clk   (clk),
        .nrst  (nrst),
        .start (acc & is_hb),
        .degen (degen),
        .num   (energy - e_min),
        .den   (e_max - e_min),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hopsFromSink <= MAX_HOPS;
            myQValue     <= '0;
            role         <= 1'b0;
            low_E        <= 1'b0;
            myCH         <= '0;
            myTimeslot   <= '0;
            q_valid      <= 1'b0;
        end else begin
            q_valid <= div_done;
            if (div_done) myQValue <= div_q;
            if (acc) begin
                if (energy < e_threshold)  low_E <= 1'b1;
                else if (energy >= thr_hi) low_E <= 1'b0;
                if (is_hb && hops < MAX_HOPS - WIDTH'(1)
                    && hops + WIDTH'(1) < hopsFromSink)
                    hopsFromSink <= hops + WIDTH'(1);
                if (is_che) begin
                    role <= (ch_ID == MY_NODE_ID);
                    myCH <= ch_ID;
                end
                if (is_cht && ch_ID == myCH) myTimeslot <= timeslot;
            end
        end
    end

    assign myNodeID = MY_NODE_ID;
    assign busy     = div_busy;

endmodule

// File: tb/tb_node_info_mgr.sv
// Directed self-checking bench for node_info_mgr.
module tb_node_info_mgr;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en_MNI = 1'b0;
    logic [2:0]  fPktType = 3'd7;
    logic [15:0] e_max = '0, e_min = '0, energy = '0, ch_ID = '0;
    logic [15:0] hops = '0, timeslot = '0, e_threshold = 16'h3333;
    logic [15:0] myNodeID, hopsFromSink, myQValue, myCH, myTimeslot;
    logic        role, low_E, busy, q_valid;

    int tests = 0;
    int fails = 0;

    node_info_mgr dut (
        .clk          (clk),
        .nrst         (nrst),
        .en_MNI       (en_MNI),
        .fPktType     (fPktType),
        .e_max        (e_max),
        .e_min        (e_min),
        .energy       (energy),
        .ch_ID        (ch_ID),
        .hops         (hops),
        .timeslot     (timeslot),
        .e_threshold  (e_threshold),
        .myNodeID     (myNodeID),
        .hopsFromSink (hopsFromSink),
        .myQValue     (myQValue),
        .role         (role),
        .low_E        (low_E),
        .myCH         (myCH),
        .myTimeslot   (myTimeslot),
        .busy         (busy),
        .q_valid      (q_valid)
    );

    always #5 clk = ~clk;

    // Drives one packet across exactly one rising edge; returns at the
    // following falling edge.
    task automatic send(input logic [2:0] t, input logic [15:0] emx,
                        input logic [15:0] emn, input logic [15:0] en,
                        input logic [15:0] h, input logic [15:0] id,
                        input logic [15:0] ts);
        @(negedge clk);
        fPktType = t; e_max = emx; e_min = emn; energy = en;
        hops = h; ch_ID = id; timeslot = ts; en_MNI = 1'b1;
        @(negedge clk);
        en_MNI = 1'b0;
    endtask

    task automatic wait_q(output int n);
        n = 0;
        while (!q_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic hb(input logic [15:0] emx, input logic [15:0] emn,
                      input logic [15:0] en, input logic [15:0] h,
                      output int n);
        send(3'd0, emx, emn, en, h, 16'h0, 16'h0);
        wait_q(n);
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (hopsFromSink !== 16'hFFFF || myQValue !== 16'h0 ||
            role !== 1'b0 || low_E !== 1'b0 || myCH !== 16'h0 ||
            myTimeslot !== 16'h0 || busy !== 1'b0 || q_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset: hops=%h q=%h role=%b lowE=%b ch=%h ts=%h busy=%b qv=%b",
                     hopsFromSink, myQValue, role, low_E, myCH, myTimeslot, busy, q_valid);
        end
        tests++;
        if (myNodeID !== 16'h0001) begin
            fails++;
            $display("FAIL node_id: got %h want 0001", myNodeID);
        end
        nrst = 1'b1;
    endtask

    task automatic test_hb_basic;
        int n;
        send(3'd0, 16'h8000, 16'h4000, 16'h8000, 16'd1, 16'h0, 16'h0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        wait_q(n);
        tests++;
        if (n !== 16) begin
            fails++;
            $display("FAIL latency: got %0d want 16", n);
        end
        tests++;
        if (myQValue !== 16'h4000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL q_full: q=%h busy=%b want 4000 0", myQValue, busy);
        end
        tests++;
        if (hopsFromSink !== 16'd2 || low_E !== 1'b0) begin
            fails++;
            $display("FAIL hb_hops: hops=%h lowE=%b want 2 0", hopsFromSink, low_E);
        end
        @(negedge clk);
        tests++;
        if (q_valid !== 1'b0) begin
            fails++;
            $display("FAIL qv_pulse: got %b want 0", q_valid);
        end
    endtask

    task automatic test_hb_hops;
        int n;
        hb(16'h8000, 16'h4000, 16'h6000, 16'd5, n);
        tests++;
        if (myQValue !== 16'h2000 || hopsFromSink !== 16'd2) begin
            fails++;
            $display("FAIL q_half: q=%h hops=%h want 2000 2", myQValue, hopsFromSink);
        end
        hb(16'h8000, 16'h4000, 16'h6000, 16'hFFFE, n);
        tests++;
        if (hopsFromSink !== 16'd2) begin
            fails++;
            $display("FAIL hops_max: got %h want 2", hopsFromSink);
        end
        hb(16'h8000, 16'h4000, 16'h5000, 16'd0, n);
        tests++;
        if (hopsFromSink !== 16'd1 || myQValue !== 16'h1000) begin
            fails++;
            $display("FAIL hops_min: hops=%h q=%h want 1 1000", hopsFromSink, myQValue);
        end
    endtask

    task automatic test_degenerate;
        int n;
        hb(16'h4000, 16'h4000, 16'h5000, 16'd9, n);
        tests++;
        if (myQValue !== 16'h0 || n !== 16) begin
            fails++;
            $display("FAIL degen_range: q=%h lat=%0d want 0 16", myQValue, n);
        end
        hb(16'h8000, 16'h4000, 16'h6000, 16'd9, n);
        hb(16'h8000, 16'h4000, 16'h3000, 16'd9, n);
        tests++;
        if (myQValue !== 16'h0 || low_E !== 1'b1) begin
            fails++;
            $display("FAIL degen_low: q=%h lowE=%b want 0 1", myQValue, low_E);
        end
        hb(16'h8000, 16'h4000, 16'hA000, 16'd9, n);
        tests++;
        if (myQValue !== 16'h4000 || n !== 16 || low_E !== 1'b0) begin
            fails++;
            $display("FAIL sat: q=%h lat=%0d lowE=%b want 4000 16 0", myQValue, n, low_E);
        end
    endtask

    task automatic test_cluster;
        send(3'd1, 16'h0, 16'h0, 16'h8000, 16'd9, 16'h0001, 16'h0);
        tests++;
        if (role !== 1'b1 || myCH !== 16'h0001) begin
            fails++;
            $display("FAIL che_self: role=%b ch=%h want 1 0001", role, myCH);
        end
        send(3'd2, 16'h0, 16'h0, 16'h8000, 16'd9, 16'h0001, 16'd7);
        tests++;
        if (myTimeslot !== 16'd7) begin
            fails++;
            $display("FAIL cht_match: got %h want 7", myTimeslot);
        end
        send(3'd2, 16'h0, 16'h0, 16'h8000, 16'd9, 16'h0009, 16'd3);
        tests++;
        if (myTimeslot !== 16'd7) begin
            fails++;
            $display("FAIL cht_other: got %h want 7", myTimeslot);
        end
        send(3'd1, 16'h0, 16'h0, 16'h8000, 16'd9, 16'h0005, 16'h0);
        tests++;
        if (role !== 1'b0 || myCH !== 16'h0005 || busy !== 1'b0) begin
            fails++;
            $display("FAIL che_other: role=%b ch=%h busy=%b want 0 0005 0", role, myCH, busy);
        end
    endtask

    task automatic test_low_e;
        send(3'd3, 16'h0, 16'h0, 16'h3000, 16'd9, 16'h0, 16'h0);
        tests++;
        if (low_E !== 1'b1) begin
            fails++;
            $display("FAIL lowe_set: got %b want 1", low_E);
        end
        send(3'd3, 16'h0, 16'h0, 16'h3400, 16'd9, 16'h0, 16'h0);
        tests++;
        if (low_E !== 1'b1) begin
            fails++;
            $display("FAIL lowe_hold: got %b want 1", low_E);
        end
        send(3'd3, 16'h0, 16'h0, 16'h3700, 16'd9, 16'h0, 16'h0);
        tests++;
        if (low_E !== 1'b0) begin
            fails++;
            $display("FAIL lowe_clr: got %b want 0", low_E);
        end
    endtask

    task automatic test_busy_and_abort;
        int n;
        int seen;
        send(3'd0, 16'h8000, 16'h4000, 16'h6000, 16'd9, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        send(3'd1, 16'h0, 16'h0, 16'h6000, 16'd9, 16'h0001, 16'h0);
        tests++;
        if (role !== 1'b0 || myCH !== 16'h0005) begin
            fails++;
            $display("FAIL busy_ignore: role=%b ch=%h want 0 0005", role, myCH);
        end
        wait_q(n);
        @(negedge clk);
        send(3'd0, 16'h8000, 16'h4000, 16'h3000, 16'd9, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        tests++;
        if (low_E !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort: lowE=%b busy=%b want 1 1", low_E, busy);
        end
        #2 nrst = 1'b0;
        #2;
        tests++;
        if (hopsFromSink !== 16'hFFFF || myQValue !== 16'h0 || role !== 1'b0 ||
            low_E !== 1'b0 || myCH !== 16'h0 || myTimeslot !== 16'h0 ||
            busy !== 1'b0 || q_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: hops=%h q=%h role=%b lowE=%b ch=%h ts=%h busy=%b",
                     hopsFromSink, myQValue, role, low_E, myCH, myTimeslot, busy);
        end
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_noqv: got %0d pulses want 0", seen);
        end
        hb(16'h8000, 16'h4000, 16'h7000, 16'd3, n);
        tests++;
        if (myQValue !== 16'h3000 || n !== 16 || hopsFromSink !== 16'd4) begin
            fails++;
            $display("FAIL post_abort: q=%h lat=%0d hops=%h want 3000 16 4",
                     myQValue, n, hopsFromSink);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        hb(16'h8000, 16'h4000, 16'h8000, 16'd3, n);
        fPktType = 3'd1; ch_ID = 16'h0022; energy = 16'h8000; en_MNI = 1'b1;
        @(negedge clk);
        en_MNI = 1'b0;
        tests++;
        if (myCH !== 16'h0022 || myQValue !== 16'h4000) begin
            fails++;
            $display("FAIL b2b: ch=%h q=%h want 0022 4000", myCH, myQValue);
        end
    endtask

    initial begin
        test_reset();
        test_hb_basic();
        test_hb_hops();
        test_degenerate();
        test_cluster();
        test_low_e();
        test_busy_and_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim exceeded 200000 time units");
        $fatal(1);
    end

endmodule
